// File: rtl/sram_ctrl_pkg.sv
// Shared widths and the request bundle for the sram6t128x48 initiator.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W     = 7;
    localparam int SRAM_DATA_W     = 48;
    localparam int SRAM_BYTES      = 6;
    localparam int SRAM_RESP_DEPTH = 4;
    // Bits covered by one write-mask bit.
    localparam int SRAM_LANE_W     = SRAM_DATA_W / SRAM_BYTES;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_BYTES-1:0]  wmask;
    } sram_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small in-order synchronous FIFO; occupancy tracked by a count so that
// full and empty are unambiguous, pointers wrap modulo DEPTH.
module sram_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for sram6t128x48 macros: registers SRAM pins
// from accepted requests and returns read data in order through a FIFO.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits for ready, and ready here is a function of
// registered state only (no path from resp_ready or req_valid into req_ready).
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int BYTES      = SRAM_BYTES,
    parameter int RESP_DEPTH = SRAM_RESP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BYTES-1:0]  req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [BYTES-1:0]  sram_wbm,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int OW = $clog2(RESP_DEPTH + 1);

    logic          accept;
    logic          rd_accept;
    logic          resp_fire;
    logic          rd_p1;       // read is on the pins, SRAM samples next edge
    logic          rd_p2;       // read data is on sram_o, captured next edge
    logic [OW-1:0] outstanding; // reads in the pipeline plus FIFO entries
    logic [OW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Credits cover every read that could still land in the FIFO, so it cannot overflow.
    assign req_ready  = ~reset & (outstanding < OW'(RESP_DEPTH));
    assign accept     = req_valid & req_ready;
    assign rd_accept  = accept & ~req_write;
    assign resp_valid = ~fifo_empty;
    assign resp_fire  = resp_valid & resp_ready;
    assign sram_oeb   = 1'b0;

    // SRAM pin register: select only in cycles following an accept; address and data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_csb <= 1'b1;
            sram_web <= 1'b1;
            sram_a   <= '0;
            sram_wbm <= '0;
            sram_i   <= '0;
        end else if (accept) begin
            sram_csb <= 1'b0;
            sram_web <= ~req_write;
            sram_a   <= req_addr;
            if (req_write) begin
                sram_wbm <= req_wmask;
                sram_i   <= req_wdata;
            end else begin
                sram_wbm <= '0;
            end
        end else begin
            sram_csb <= 1'b1;
        end
    end

    // Read flag travels alongside the pins so the FIFO captures sram_o at the right edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p1 <= 1'b0;
            rd_p2 <= 1'b0;
        end else begin
            rd_p1 <= rd_accept;
            rd_p2 <= rd_p1;
        end
    end

    // Credit counter: up on read accept, down on response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, resp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_p2),
        .wdata (sram_o),
        .pop   (resp_ready),
        .rdata (resp_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Invariants: credits equal in-flight reads plus queued data, and captures never hit a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (outstanding == fifo_count + OW'(rd_p1) + OW'(rd_p2));
            assert (!(fifo_full && rd_p2 && !resp_ready));
        end
    end

endmodule
